cnn_sdiv_23s_9s_14s_seq: RTL and testbench

Sequential signed divider. It is the inverse path of the 14s x 9s -> 23s DSP product used in the conv layers: it divides a 23-bit signed accumulator value by a 9-bit signed scale or divisor. It returns a 14-bit signed saturated quotient and a 9-bit signed remainder. Used by the requantization and average-pool stages; one radix-2 iteration per clock, so no DSP is consumed.

---
 rtl/cnn_sdiv_23s_9s_14s_seq.sv | 174 +++++++++++++++++
 tb/tb_cnn_sdiv_23s_9s_14s_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cnn_sdiv_23s_9s_14s_seq.sv
`default_nettype none
// ============================================================================
// Module   : cnn_sdiv_23s_9s_14s_seq
// Brief    : Sequential radix-2 restoring signed divider, saturated quotient.
// Revision : 1.0
// ============================================================================
module cnn_sdiv_23s_9s_14s_seq #(
    parameter int DIVIDEND_WIDTH = 23,
    parameter int DIVISOR_WIDTH  = 9,
    parameter int QUOTIENT_WIDTH = 14
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [QUOTIENT_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      ovf,
    output logic                      div_by_zero
);

    localparam int c_CNT_W = $clog2(DIVIDEND_WIDTH);
    localparam int c_SHF_W = DIVISOR_WIDTH + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIVIDEND_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [DIVIDEND_WIDTH-1:0] c_POS_LIM = DIVIDEND_WIDTH'(2**(QUOTIENT_WIDTH-1) - 1);
    localparam logic [DIVIDEND_WIDTH-1:0] c_NEG_LIM = DIVIDEND_WIDTH'(2**(QUOTIENT_WIDTH-1));
    localparam logic [QUOTIENT_WIDTH-1:0] c_Q_MAX = {1'b0, {(QUOTIENT_WIDTH-1){1'b1}}};
    localparam logic [QUOTIENT_WIDTH-1:0] c_Q_MIN = {1'b1, {(QUOTIENT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DIVIDEND_WIDTH-1:0] r_qdiv;     // dividend magnitude, becomes quotient magnitude
    logic [DIVISOR_WIDTH-1:0]  r_dvs_mag;
    logic [DIVISOR_WIDTH-1:0]  r_part;
    logic [c_CNT_W-1:0]        r_cnt;
    logic                      r_sign_n;
    logic                      r_sign_d;
    logic                      r_dz;

    logic [QUOTIENT_WIDTH-1:0] r_quot;
    logic [DIVISOR_WIDTH-1:0]  r_rem;
    logic                      r_ovf;
    logic                      r_dz_out;

    logic [DIVIDEND_WIDTH-1:0] w_dvd_abs;
    logic [DIVISOR_WIDTH-1:0]  w_dvs_abs;
    logic [c_SHF_W-1:0]        w_shift;
    logic                      w_ge;
    logic [DIVISOR_WIDTH-1:0]  w_part_nxt;
    logic [QUOTIENT_WIDTH-1:0] w_q_fix;
    logic [DIVISOR_WIDTH-1:0]  w_r_fix;
    logic                      w_ovf_fix;

    assign w_dvd_abs = dividend[DIVIDEND_WIDTH-1] ? ({DIVIDEND_WIDTH{1'b0}} - dividend) : dividend;
    assign w_dvs_abs = divisor[DIVISOR_WIDTH-1]   ? ({DIVISOR_WIDTH{1'b0}} - divisor)   : divisor;

    // The true difference is below the divisor magnitude, so 9-bit wraparound is exact.
    assign w_shift    = {r_part, r_qdiv[DIVIDEND_WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs_mag});
    assign w_part_nxt = w_ge ? (w_shift[DIVISOR_WIDTH-1:0] - r_dvs_mag) : w_shift[DIVISOR_WIDTH-1:0];

    always_comb begin
        w_q_fix   = r_qdiv[QUOTIENT_WIDTH-1:0];
        w_ovf_fix = 1'b0;
        w_r_fix   = r_sign_n ? ({DIVISOR_WIDTH{1'b0}} - r_part) : r_part;
        if (r_dz) begin
            w_q_fix = r_sign_n ? c_Q_MIN : c_Q_MAX;
            w_r_fix = '0;
        end else if (r_sign_n ^ r_sign_d) begin
            if (r_qdiv > c_NEG_LIM) begin
                w_q_fix   = c_Q_MIN;
                w_ovf_fix = 1'b1;
            end else begin
                w_q_fix = {QUOTIENT_WIDTH{1'b0}} - r_qdiv[QUOTIENT_WIDTH-1:0];
            end
        end else if (r_qdiv > c_POS_LIM) begin
            w_q_fix   = c_Q_MAX;
            w_ovf_fix = 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_CALC;
            end
            S_CALC: begin
                if (r_cnt == c_CNT_LAST) w_state_nxt = S_FIX;
            end
            S_FIX: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_qdiv    <= '0;
            r_dvs_mag <= '0;
            r_part    <= '0;
            r_cnt     <= '0;
            r_sign_n  <= 1'b0;
            r_sign_d  <= 1'b0;
            r_dz      <= 1'b0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_ovf     <= 1'b0;
            r_dz_out  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_qdiv    <= w_dvd_abs;
                        r_dvs_mag <= w_dvs_abs;
                        r_sign_n  <= dividend[DIVIDEND_WIDTH-1];
                        r_sign_d  <= divisor[DIVISOR_WIDTH-1];
                        r_dz      <= (divisor == '0);
                        r_part    <= '0;
                        r_cnt     <= '0;
                    end
                end
                S_CALC: begin
                    r_part <= w_part_nxt;
                    r_qdiv <= {r_qdiv[DIVIDEND_WIDTH-2:0], w_ge};
                    r_cnt  <= r_cnt + c_CNT_ONE;
                end
                S_FIX: begin
                    r_quot   <= w_q_fix;
                    r_rem    <= w_r_fix;
                    r_ovf    <= w_ovf_fix;
                    r_dz_out <= r_dz;
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign ovf         = r_ovf;
    assign div_by_zero = r_dz_out;

endmodule
`default_nettype wire

// File: tb/tb_cnn_sdiv_23s_9s_14s_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_sdiv_23s_9s_14s_seq
// Brief    : Scoreboard bench for the sequential signed divider.
// Revision : 1.0
// ============================================================================
module tb_cnn_sdiv_23s_9s_14s_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [22:0] dividend = '0;
    logic [8:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [13:0] quotient;
    logic [8:0]  remainder;
    logic        ovf;
    logic        div_by_zero;

    cnn_sdiv_23s_9s_14s_seq dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .ovf         (ovf),
        .div_by_zero (div_by_zero)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int q;
        int r;
        int ovf;
        int dz;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   seen = 1'b0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Monitor: latency on first sight of a result, field checks at the handshake.
    always @(negedge ap_clk) begin
        if (!out_valid) begin
            seen = 1'b0;
        end else if (ap_rst_n) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
                else                chk("latency", cyc - sb[0].acc, 24);
            end
            if (out_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient",    int'($signed(quotient)),  e.q);
                chk("remainder",   int'($signed(remainder)), e.r);
                chk("ovf",         int'(ovf),                e.ovf);
                chk("div_by_zero", int'(div_by_zero),        e.dz);
            end
        end
    end

    task automatic issue(input int a, input int b, input int eq, input int er,
                         input int eo, input int ez);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge ap_clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        dividend = a[22:0];
        divisor  = b[8:0];
        @(posedge ap_clk); #1;
        e.q = eq; e.r = er; e.ovf = eo; e.dz = ez; e.acc = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
        dividend = 23'h2AAAAA;
        divisor  = 9'h155;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge ap_clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("result_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge ap_clk); #1;
    endtask

    task automatic op(input int a, input int b, input int eq, input int er,
                      input int eo, input int ez);
        issue(a, b, eq, er, eo, ez);
        wait_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_in_ready",  int'(in_ready),    1);
        chk("rst_out_valid", int'(out_valid),   0);
        chk("rst_quotient",  int'(quotient),    0);
        chk("rst_remainder", int'(remainder),   0);
        chk("rst_ovf",       int'(ovf),         0);
        chk("rst_dz",        int'(div_by_zero), 0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;

        op(1000, 7, 142, 6, 0, 0);
        op(-1000, 7, -142, -6, 0, 0);
        op(1000, -7, -142, 6, 0, 0);
        op(-1000, -7, 142, -6, 0, 0);
        op(-256, -256, 1, 0, 0, 0);
        op(0, 5, 0, 0, 0, 0);
        op(4194303, 1, 8191, 0, 1, 0);
        op(-4194304, -1, 8191, 0, 1, 0);
        op(-4194304, 1, -8192, 0, 1, 0);
        op(8191, 1, 8191, 0, 0, 0);
        op(8192, 1, 8191, 0, 1, 0);
        op(-8192, 1, -8192, 0, 0, 0);
        op(5, 0, 8191, 0, 0, 1);
        op(-5, 0, -8192, 0, 0, 1);

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        issue(12345, -100, -123, 45, 0, 0);
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge ap_clk); #1;
            n++;
        end
        chk("bp_out_valid_seen", int'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_in_ready",  int'(in_ready),             0);
            chk("bp_out_valid", int'(out_valid),            1);
            chk("bp_quotient",  int'($signed(quotient)),  -123);
            chk("bp_remainder", int'($signed(remainder)),  45);
            in_valid = (i == 3);
            dividend = 23'd1;
            divisor  = 9'd1;
            @(posedge ap_clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge ap_clk); #1;
        chk("bp_release_in_ready",  int'(in_ready),  1);
        chk("bp_release_out_valid", int'(out_valid), 0);
        chk("bp_queue_empty",       sb.size(),       0);

        op(77, 9, 8, 5, 0, 0);
        op(-77, 9, -8, -5, 0, 0);

        // Reset in the middle of a calculation discards it.
        in_valid = 1'b1;
        dividend = 23'd500;
        divisor  = 9'd3;
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b0;
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        chk("midrst_in_ready",  int'(in_ready),  1);
        chk("midrst_out_valid", int'(out_valid), 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) n++;
            @(posedge ap_clk); #1;
        end
        chk("midrst_no_output", n, 0);

        op(100, 3, 33, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
